// File: rtl/io_dev_responder_pkg.sv
// Shared constants for the KV10 I/O-bus device responder.
// Word bits use PDP-10 numbering (bit 0 = MSB); pdp_bit() maps them onto [35:0] vectors.
package io_dev_responder_pkg;

    localparam int WORD_W = 36;
    localparam int DEV_W  = 7;
    localparam int PI_W   = 3;
    localparam int CNT_W  = 4;

    function automatic int pdp_bit(input int b);
        return WORD_W - 1 - b;
    endfunction

    // CONI/CONO field positions, as [35:0] indices
    localparam int PI_LSB      = pdp_bit(35);
    localparam int TX_DONE_BIT = pdp_bit(32);
    localparam int TX_BUSY_BIT = pdp_bit(31);
    localparam int RX_DONE_BIT = pdp_bit(30);
    localparam int RX_OVR_BIT  = pdp_bit(29);
    localparam int LOOP_BIT    = pdp_bit(28);

    // Encoding is {io_cond, io_write}
    typedef enum logic [1:0] {
        OP_DATAI = 2'b00,
        OP_DATAO = 2'b01,
        OP_CONI  = 2'b10,
        OP_CONO  = 2'b11
    } io_op_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_WAIT,
        HS_ACK,
        HS_DROP
    } hs_state_e;

    // PI channel c (1..7) drives pi_req bit [1:7] position c, i.e. vector index 7-c.
    function automatic logic [6:0] pi_onehot(input logic [PI_W-1:0] pi);
        logic [6:0] mask;
        mask = '0;
        if (pi != '0) mask = 7'b1000000 >> (pi - 3'd1);
        return mask;
    endfunction

endpackage

// File: rtl/io_bus_handshake.sv
// CPU-side 4-phase req/ack FSM (IDLE/WAIT/ACK/DROP) with programmable ack delay.
// Emits a one-cycle do_op strobe with the captured op/word; device state lives in the parent.
module io_bus_handshake
    import io_dev_responder_pkg::*;
#(
    parameter logic [DEV_W-1:0] DEVICE    = 7'o024,
    parameter int               ACK_DELAY = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_req,
    input  logic [DEV_W-1:0]  io_dev,
    input  logic              io_cond,
    input  logic              io_write,
    input  logic [WORD_W-1:0] io_wdata,
    output logic              io_ack,
    output logic              do_op,
    output logic              ack_drop,
    output io_op_e            op,
    output logic [WORD_W-1:0] wdata
);

    hs_state_e        state;
    logic [CNT_W-1:0] count;

    // The side effect fires on the same edge that raises io_ack, so it happens exactly once.
    assign do_op    = (state == HS_WAIT) && io_req && (count == '0);
    assign ack_drop = (state == HS_ACK) && !io_req;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= HS_IDLE;
            count  <= '0;
            io_ack <= 1'b0;
            op     <= OP_DATAI;
            wdata  <= '0;
        end else begin
            case (state)
                HS_IDLE: begin
                    if (io_req && (io_dev == DEVICE)) begin
                        op    <= io_op_e'({io_cond, io_write});
                        wdata <= io_wdata;
                        count <= CNT_W'(ACK_DELAY);
                        state <= HS_WAIT;
                    end
                end
                HS_WAIT: begin
                    if (!io_req) begin
                        state <= HS_IDLE;
                    end else if (count == '0) begin
                        io_ack <= 1'b1;
                        state  <= HS_ACK;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                HS_ACK: begin
                    if (!io_req) begin
                        io_ack <= 1'b0;
                        state  <= HS_DROP;
                    end
                end
                HS_DROP: state <= HS_IDLE;
                default: state <= HS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/io_dev_responder.sv
// TTY-style KV10 I/O device: TX/RX buffers, condition flags, PI channel and one-hot PI request.
// Optional IO_DEV_LOOPBACK_EN adds a LOOP flag (CONO/CONI bit 28) that feeds TX words back into RX.
module io_dev_responder
    import io_dev_responder_pkg::*;
#(
    parameter logic [DEV_W-1:0] DEVICE    = 7'o024,
    parameter int               ACK_DELAY = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_req,
    input  logic [DEV_W-1:0]  io_dev,
    input  logic              io_cond,
    input  logic              io_write,
    input  logic [WORD_W-1:0] io_wdata,
    output logic [WORD_W-1:0] io_rdata,
    output logic              io_ack,
    output logic [WORD_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [WORD_W-1:0] rx_data,
    input  logic              rx_strobe,
    output logic [6:0]        pi_req
);

    logic              do_op;
    logic              ack_drop;
    io_op_e            op;
    logic [WORD_W-1:0] wdata;

    logic [PI_W-1:0]   pi_q;
    logic              tx_done, tx_busy, rx_done, rx_ovr;
    logic [WORD_W-1:0] rx_buf;
    logic [WORD_W-1:0] coni_word;
    logic              tx_fire, rx_set;
    logic [WORD_W-1:0] rx_word;
    logic              is_cono, is_datao, is_datai;

    io_bus_handshake #(
        .DEVICE    (DEVICE),
        .ACK_DELAY (ACK_DELAY)
    ) u_handshake (
        .clk      (clk),
        .reset_n  (reset_n),
        .io_req   (io_req),
        .io_dev   (io_dev),
        .io_cond  (io_cond),
        .io_write (io_write),
        .io_wdata (io_wdata),
        .io_ack   (io_ack),
        .do_op    (do_op),
        .ack_drop (ack_drop),
        .op       (op),
        .wdata    (wdata)
    );

    assign is_cono  = do_op && (op == OP_CONO);
    assign is_datao = do_op && (op == OP_DATAO);
    assign is_datai = do_op && (op == OP_DATAI);

`ifdef IO_DEV_LOOPBACK_EN
    logic              loop_q;
    logic              loop_strobe_q;
    logic [WORD_W-1:0] loop_word_q;

    // In loopback the word completes one cycle after tx_valid and returns as an internal strobe.
    assign tx_fire = tx_valid && (loop_q || tx_ready);
    assign rx_set  = rx_strobe || loop_strobe_q;
    assign rx_word = loop_strobe_q ? loop_word_q : rx_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loop_q        <= 1'b0;
            loop_strobe_q <= 1'b0;
            loop_word_q   <= '0;
        end else begin
            if (is_cono) loop_q <= wdata[LOOP_BIT];
            loop_strobe_q <= tx_fire && loop_q;
            if (tx_fire) loop_word_q <= tx_data;
        end
    end
`else
    assign tx_fire = tx_valid && tx_ready;
    assign rx_set  = rx_strobe;
    assign rx_word = rx_data;
`endif

    // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        coni_word                       = '0;
        coni_word[PI_LSB +: PI_W]       = pi_q;
        coni_word[TX_DONE_BIT]          = tx_done;
        coni_word[TX_BUSY_BIT]          = tx_busy;
        coni_word[RX_DONE_BIT]          = rx_done;
        coni_word[RX_OVR_BIT]           = rx_ovr;
`ifdef IO_DEV_LOOPBACK_EN
        coni_word[LOOP_BIT]             = loop_q;
`endif
    end

    // Software clears are written first so same-cycle hardware sets override them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pi_q     <= '0;
            tx_done  <= 1'b0;
            tx_busy  <= 1'b0;
            rx_done  <= 1'b0;
            rx_ovr   <= 1'b0;
            rx_buf   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            if (is_cono) begin
                pi_q <= wdata[PI_LSB +: PI_W];
                if (wdata[TX_DONE_BIT]) tx_done <= 1'b0;
                if (wdata[RX_DONE_BIT]) rx_done <= 1'b0;
                if (wdata[RX_OVR_BIT])  rx_ovr  <= 1'b0;
            end
            if (is_datai) rx_done <= 1'b0;

            if (is_datao) begin
                tx_data  <= wdata;
                tx_valid <= 1'b1;
                tx_busy  <= 1'b1;
                tx_done  <= 1'b0;
            end else if (tx_fire) begin
                tx_valid <= 1'b0;
                tx_busy  <= 1'b0;
                tx_done  <= 1'b1;
            end

            if (rx_set) begin
                rx_buf  <= rx_word;
                rx_done <= 1'b1;
                if (rx_done) rx_ovr <= 1'b1;
            end
        end
    end

    // io_rdata is non-zero only while this device is acking (wired-OR bus).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            io_rdata <= '0;
        end else if (do_op) begin
            case (op)
                OP_CONI:  io_rdata <= coni_word;
                OP_DATAI: io_rdata <= rx_buf;
                default:  io_rdata <= '0;
            endcase
        end else if (ack_drop) begin
            io_rdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pi_req <= '0;
        end else begin
            pi_req <= (tx_done || rx_done) ? pi_onehot(pi_q) : '0;
        end
    end

endmodule

// File: tb/tb_io_dev_responder.sv
// Directed bench for io_dev_responder: dut (ACK_DELAY=0) plus dut_d3 (ACK_DELAY=3) for abort/delay cases.
// Loopback checks are compiled only when IO_DEV_LOOPBACK_EN is defined.
module tb_io_dev_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        io_req, io_req3;
    logic [6:0]  io_dev;
    logic        io_cond, io_write;
    logic [35:0] io_wdata;
    logic [35:0] io_rdata, io_rdata3;
    logic        io_ack, io_ack3;
    logic [35:0] tx_data, tx_data3;
    logic        tx_valid, tx_valid3;
    logic        tx_ready;
    logic [35:0] rx_data;
    logic        rx_strobe;
    logic [6:0]  pi_req, pi_req3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_dev_responder #(.DEVICE(7'o024), .ACK_DELAY(0)) dut (
        .clk(clk), .reset_n(reset_n), .io_req(io_req), .io_dev(io_dev),
        .io_cond(io_cond), .io_write(io_write), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_strobe(rx_strobe), .pi_req(pi_req)
    );

    io_dev_responder #(.DEVICE(7'o024), .ACK_DELAY(3)) dut_d3 (
        .clk(clk), .reset_n(reset_n), .io_req(io_req3), .io_dev(io_dev),
        .io_cond(io_cond), .io_write(io_write), .io_wdata(io_wdata),
        .io_rdata(io_rdata3), .io_ack(io_ack3), .tx_data(tx_data3), .tx_valid(tx_valid3),
        .tx_ready(1'b0), .rx_data(rx_data), .rx_strobe(1'b0), .pi_req(pi_req3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    // Full 4-phase transaction; ok=0 if no ack within the budget.
    task automatic bus_op(input bit sel3, input logic cond, input logic write,
                          input logic [6:0] dev, input logic [35:0] wd,
                          output logic [35:0] rd, output bit ok);
        ok = 1'b0;
        rd = '0;
        @(negedge clk);
        io_dev   = dev;
        io_cond  = cond;
        io_write = write;
        io_wdata = wd;
        if (sel3) io_req3 = 1'b1; else io_req = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (sel3 ? io_ack3 : io_ack) begin
                ok = 1'b1;
                rd = sel3 ? io_rdata3 : io_rdata;
            end
        end
        io_req  = 1'b0;
        io_req3 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(sel3 ? io_ack3 : io_ack)) break;
        end
        @(negedge clk);
    endtask

    task automatic do_cono(input string tag, input bit sel3, input logic [35:0] wd);
        logic [35:0] rd;
        bit          ok;
        bus_op(sel3, 1'b1, 1'b1, 7'o024, wd, rd, ok);
        check({tag, "_ack"}, 64'(ok), 64'd1);
    endtask

    task automatic do_datao(input string tag, input logic [35:0] wd);
        logic [35:0] rd;
        bit          ok;
        bus_op(1'b0, 1'b0, 1'b1, 7'o024, wd, rd, ok);
        check({tag, "_ack"}, 64'(ok), 64'd1);
    endtask

    task automatic expect_read(input string tag, input bit sel3, input logic cond,
                               input logic [35:0] exp);
        logic [35:0] rd;
        bit          ok;
        bus_op(sel3, cond, 1'b0, 7'o024, 36'd0, rd, ok);
        check({tag, "_ack"}, 64'(ok), 64'd1);
        check(tag, 64'(rd), 64'(exp));
    endtask

    initial begin
        bit seen;
        io_req = 0; io_req3 = 0; io_dev = 0; io_cond = 0; io_write = 0; io_wdata = 0;
        tx_ready = 0; rx_data = 0; rx_strobe = 0;
        reset_n = 0;
        repeat (3) @(negedge clk);
        check("rst_ack",    64'(io_ack),   64'd0);
        check("rst_rdata",  64'(io_rdata), 64'd0);
        check("rst_txv",    64'(tx_valid), 64'd0);
        check("rst_txdata", 64'(tx_data),  64'd0);
        check("rst_pi",     64'(pi_req),   64'd0);
        reset_n = 1;
        @(negedge clk);

        // Minimum latency: captured at edge N, ack visible after edge N+1.
        io_dev = 7'o024; io_cond = 1; io_write = 1; io_wdata = 36'o000005; io_req = 1;
        @(negedge clk);
        check("lat_ack_n1", 64'(io_ack), 64'd0);
        @(negedge clk);
        check("lat_ack_n2", 64'(io_ack), 64'd1);
        check("lat_rdata",  64'(io_rdata), 64'd0);
        io_req = 0;
        @(negedge clk);
        check("lat_ack_fall", 64'(io_ack), 64'd0);
        @(negedge clk);
        expect_read("coni_pi5", 1'b0, 1'b1, 36'o000005);
        check("pi_idle", 64'(pi_req), 64'd0);

        // DATAO then delayed accept.
        do_datao("datao", 36'o123456701234);
        check("tx_data",  64'(tx_data),  64'(36'o123456701234));
        check("tx_valid", 64'(tx_valid), 64'd1);
        check("pi_busy",  64'(pi_req),   64'd0);
        expect_read("coni_busy", 1'b0, 1'b1, 36'o000025);
        check("tx_held", 64'(tx_valid), 64'd1);
        @(negedge clk); tx_ready = 1;
        @(negedge clk); tx_ready = 0;
        check("tx_accepted", 64'(tx_valid), 64'd0);
        expect_read("coni_txdone", 1'b0, 1'b1, 36'o000015);
        check("pi_txdone", 64'(pi_req), 64'(7'b0000100));
        do_cono("cono_clr_tx", 1'b0, 36'o000015);
        expect_read("coni_txclr", 1'b0, 1'b1, 36'o000005);
        check("pi_cleared", 64'(pi_req), 64'd0);

        // Two strobes: done plus overrun.
        @(negedge clk); rx_data = 36'o777; rx_strobe = 1;
        @(negedge clk); rx_data = 36'o1;
        @(negedge clk); rx_strobe = 0;
        expect_read("coni_rxovr", 1'b0, 1'b1, 36'o000145);
        check("pi_rxdone", 64'(pi_req), 64'(7'b0000100));
        expect_read("datai_rx", 1'b0, 1'b0, 36'o000000000001);
        expect_read("coni_after_datai", 1'b0, 1'b1, 36'o000105);
        do_cono("cono_clr_ovr", 1'b0, 36'o000105);
        expect_read("coni_ovrclr", 1'b0, 1'b1, 36'o000005);

        // Foreign device number: never acked, bus stays 0.
        @(negedge clk);
        io_dev = 7'o025; io_cond = 1; io_write = 0; io_req = 1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (io_ack) seen = 1;
        end
        check("foreign_ack",   64'(seen),     64'd0);
        check("foreign_rdata", 64'(io_rdata), 64'd0);
        io_req = 0;
        @(negedge clk);

        // Request dropped during WAIT on the delayed instance.
        @(negedge clk);
        io_dev = 7'o024; io_cond = 1; io_write = 1; io_wdata = 36'o000007; io_req3 = 1;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (io_ack3) seen = 1;
        end
        io_req3 = 0;
        repeat (6) begin
            @(negedge clk);
            if (io_ack3) seen = 1;
        end
        check("abort_ack", 64'(seen), 64'd0);
        expect_read("abort_coni", 1'b1, 1'b1, 36'o000000);
        do_cono("d3_cono", 1'b1, 36'o000007);
        expect_read("d3_coni", 1'b1, 1'b1, 36'o000007);

        // rx_strobe on the same edge as a CONO clearing RX_DONE: the set wins.
        @(negedge clk);
        io_dev = 7'o024; io_cond = 1; io_write = 1; io_wdata = 36'o000045; io_req = 1;
        @(negedge clk);
        rx_data = 36'o3; rx_strobe = 1;
        @(negedge clk);
        rx_strobe = 0;
        check("race_ack", 64'(io_ack), 64'd1);
        io_req = 0;
        repeat (3) @(negedge clk);
        expect_read("race_coni", 1'b0, 1'b1, 36'o000045);
        check("race_pi", 64'(pi_req), 64'(7'b0000100));
        expect_read("race_datai", 1'b0, 1'b0, 36'o3);

`ifdef IO_DEV_LOOPBACK_EN
        do_cono("loop_on", 1'b0, 36'o000205);
        tx_ready = 0;
        do_datao("loop_datao", 36'o42);
        expect_read("loop_coni", 1'b0, 1'b1, 36'o000255);
        expect_read("loop_datai", 1'b0, 1'b0, 36'o42);
`endif

        // Reset while io_ack is high.
        @(negedge clk);
        io_dev = 7'o024; io_cond = 1; io_write = 0; io_req = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (io_ack) seen = 1;
        end
        check("pre_reset_ack", 64'(seen), 64'd1);
        reset_n = 0;
        #1;
        check("async_ack",    64'(io_ack),   64'd0);
        check("async_rdata",  64'(io_rdata), 64'd0);
        check("async_txdata", 64'(tx_data),  64'd0);
        check("async_pi",     64'(pi_req),   64'd0);
        io_req = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        expect_read("post_reset_coni", 1'b0, 1'b1, 36'o000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
